// File: rtl/dac_frame_streamer.sv
// Buffers changed rvmyth OUT samples in a small FIFO and serializes each one as a
// 16-bit SPI mode-0 frame {CMD, data, 2'b00} to an external DAC.
module dac_frame_streamer #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned GAP_CYCLES = 4,
   parameter logic [3:0]  CMD        = 4'h3
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic [9:0]               core_out,
   output logic                     SCLK,
   output logic                     SDATA,
   output logic                     CS_N,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [7:0]               drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned BW = 4;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t          state, state_d;
   logic [9:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [9:0]      last;
   logic            first_flag;
   logic [14:0]     shreg, shreg_d;
   logic [BW-1:0]   bit_cnt, bit_cnt_d;
   logic [DW-1:0]   div_cnt, div_cnt_d;
   logic [GW-1:0]   gap_cnt, gap_cnt_d;
   logic            sclk_d, sdata_d, cs_n_d, busy_d;
   logic [LW-1:0]   level_d;
   logic            change, push, pop, drop;
   logic [15:0]     frame_head;

   // Capture: a pop in the same cycle frees a slot even when the FIFO is full
   always_comb begin
      change     = first_flag | (core_out != last);
      pop        = (state == IDLE) && (fifo_level != '0);
      push       = change && ((fifo_level < LW'(DEPTH)) || pop);
      drop       = change && !push;
      frame_head = {CMD, mem[rd_ptr], 2'b00};
      unique case ({push, pop})
         2'b10:   level_d = fifo_level + LW'(1);
         2'b01:   level_d = fifo_level - LW'(1);
         default: level_d = fifo_level;
      endcase
   end

   // Frame FSM; SDATA only advances on the SCLK high->low transition
   always_comb begin
      state_d   = state;
      sclk_d    = SCLK;
      sdata_d   = SDATA;
      cs_n_d    = CS_N;
      shreg_d   = shreg;
      bit_cnt_d = bit_cnt;
      div_cnt_d = div_cnt;
      gap_cnt_d = gap_cnt;
      unique case (state)
         IDLE: begin
            if (pop) begin
               state_d   = SHIFT;
               shreg_d   = frame_head[14:0];
               sdata_d   = frame_head[15];
               cs_n_d    = 1'b0;
               sclk_d    = 1'b0;
               bit_cnt_d = '0;
               div_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (div_cnt == DW'(CLK_DIV - 1)) begin
               div_cnt_d = '0;
               if (!SCLK) begin
                  sclk_d = 1'b1;
               end else if (bit_cnt == BW'(15)) begin
                  sclk_d    = 1'b0;
                  cs_n_d    = 1'b1;
                  sdata_d   = 1'b0;
                  gap_cnt_d = '0;
                  state_d   = GAP;
               end else begin
                  sclk_d    = 1'b0;
                  sdata_d   = shreg[14];
                  shreg_d   = {shreg[13:0], 1'b0};
                  bit_cnt_d = bit_cnt + BW'(1);
               end
            end else begin
               div_cnt_d = div_cnt + DW'(1);
            end
         end
         GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE) || (level_d != '0);
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state      <= IDLE;
         SCLK       <= 1'b0;
         SDATA      <= 1'b0;
         CS_N       <= 1'b1;
         busy       <= 1'b0;
         fifo_level <= '0;
         drop_cnt   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         last       <= '0;
         first_flag <= 1'b1;
         shreg      <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         gap_cnt    <= '0;
      end else begin
         state      <= state_d;
         SCLK       <= sclk_d;
         SDATA      <= sdata_d;
         CS_N       <= cs_n_d;
         busy       <= busy_d;
         fifo_level <= level_d;
         shreg      <= shreg_d;
         bit_cnt    <= bit_cnt_d;
         div_cnt    <= div_cnt_d;
         gap_cnt    <= gap_cnt_d;
         if (change) begin
            last       <= core_out;
            first_flag <= 1'b0;
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      end
   end

   // Sample storage needs no reset; occupancy is tracked by the pointers
   always_ff @(posedge CLK) begin
      if (push && !reset) mem[wr_ptr] <= core_out;
   end

endmodule

// File: tb/tb_dac_frame_streamer.sv
// Scoreboard bench for dac_frame_streamer: expected frames are queued as samples are
// driven and popped by an SPI monitor that decodes SDATA at rising SCLK.
module tb_dac_frame_streamer;

   localparam int CLK_DIV = 2;
   localparam int GAP     = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1, reset1 = 1'b1;
   logic [9:0] core_out = 10'h155, core_out1 = 10'h001;
   logic       sclk, sdata, cs_n, busy;
   logic       sclk1, sdata1, cs_n1, busy1;
   logic [3:0] fifo_level, fifo_level1;
   logic [7:0] drop_cnt, drop_cnt1;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] exp_q[$];
   int          gap_q[$];
   bit          sb_on = 1'b0;
   int          frames_seen = 0;

   logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_sdata = 1'b0;
   logic [15:0] mon_sh = '0;
   logic [15:0] exp_f;
   int          mon_bits = 0, low_cnt = 0, high_cnt = 0;

   always #5 clk = ~clk;

   dac_frame_streamer #(.DEPTH(8), .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .CMD(4'h3)) u_dut (
      .CLK(clk), .reset(reset), .core_out(core_out), .SCLK(sclk), .SDATA(sdata),
      .CS_N(cs_n), .busy(busy), .fifo_level(fifo_level), .drop_cnt(drop_cnt));

   dac_frame_streamer #(.DEPTH(8), .CLK_DIV(1), .GAP_CYCLES(GAP), .CMD(4'h3)) u_dut1 (
      .CLK(clk), .reset(reset1), .core_out(core_out1), .SCLK(sclk1), .SDATA(sdata1),
      .CS_N(cs_n1), .busy(busy1), .fifo_level(fifo_level1), .drop_cnt(drop_cnt1));

   // SPI monitor and scoreboard for the CLK_DIV=2 instance
   always @(negedge clk) begin
      if (cs_n === 1'b0) begin
         if (prev_cs === 1'b1) begin
            low_cnt  = 1;
            mon_bits = 0;
            if (sb_on) gap_q.push_back(high_cnt);
         end else begin
            low_cnt++;
         end
         if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            mon_sh = {mon_sh[14:0], sdata};
            mon_bits++;
         end else if (sclk === 1'b1 && prev_sclk === 1'b1 && sb_on) begin
            n_assert++;
            if (sdata !== prev_sdata) begin
               n_fail++;
               $display("FAIL sdata_stable: sdata changed to %b while sclk high at %0t", sdata, $time);
            end
         end
      end else begin
         if (prev_cs === 1'b0) begin
            high_cnt = 1;
            if (sb_on) begin
               frames_seen++;
               n_assert++;
               if (mon_bits != 16) begin
                  n_fail++;
                  $display("FAIL frame_bits: got %0d bits expected 16", mon_bits);
               end
               n_assert++;
               if (low_cnt != 32 * CLK_DIV) begin
                  n_fail++;
                  $display("FAIL cs_low_len: got %0d cycles expected %0d", low_cnt, 32 * CLK_DIV);
               end
               n_assert++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL frame_unexpected: got %h expected no frame", mon_sh);
               end else begin
                  exp_f = exp_q.pop_front();
                  if (mon_sh !== exp_f) begin
                     n_fail++;
                     $display("FAIL frame_data: got %h expected %h", mon_sh, exp_f);
                  end
               end
            end
         end else begin
            high_cnt++;
         end
         mon_bits = 0;
      end
      prev_cs    = cs_n;
      prev_sclk  = sclk;
      prev_sdata = sdata;
   end

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && busy === 1'b0 && cs_n === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      core_out = 10'h155;
      exp_q.delete();
      sb_on = 1'b1;
      do_reset();
      n_assert += 6;
      if (cs_n !== 1'b1)    begin n_fail++; $display("FAIL rst_cs_n: got %b expected 1", cs_n); end
      if (sclk !== 1'b0)    begin n_fail++; $display("FAIL rst_sclk: got %b expected 0", sclk); end
      if (sdata !== 1'b0)   begin n_fail++; $display("FAIL rst_sdata: got %b expected 0", sdata); end
      if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
      if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
      if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop: got %0d expected 0", drop_cnt); end
   endtask

   task automatic test_single_frame;
      bit ok;
      int base;
      base = frames_seen;
      exp_q.push_back({4'h3, 10'h155, 2'b00});
      @(negedge clk);
      n_assert += 2;
      if (cs_n !== 1'b1)       begin n_fail++; $display("FAIL start_cs_early: got %b expected 1", cs_n); end
      if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL start_level: got %0d expected 1", fifo_level); end
      @(negedge clk);
      n_assert += 4;
      if (cs_n !== 1'b0)       begin n_fail++; $display("FAIL start_cs: got %b expected 0", cs_n); end
      if (sclk !== 1'b0)       begin n_fail++; $display("FAIL start_sclk: got %b expected 0", sclk); end
      if (sdata !== 1'b0)      begin n_fail++; $display("FAIL start_sdata: got %b expected 0", sdata); end
      if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL start_level_pop: got %0d expected 0", fifo_level); end
      wait_drain(500, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL single_timeout: got pending=%0d expected 0", exp_q.size()); end
      repeat (200) @(negedge clk);
      n_assert += 3;
      if (frames_seen - base != 1) begin n_fail++; $display("FAIL single_count: got %0d frames expected 1", frames_seen - base); end
      if (busy !== 1'b0)       begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
      if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL single_level: got %0d expected 0", fifo_level); end
   endtask

   task automatic test_back_to_back;
      bit ok;
      core_out = 10'h155;
      exp_q.delete();
      do_reset();
      gap_q.delete();
      exp_q.push_back({4'h3, 10'h155, 2'b00});
      repeat (10) @(negedge clk);
      core_out = 10'h3FF;
      exp_q.push_back({4'h3, 10'h3FF, 2'b00});
      wait_drain(1000, ok);
      n_assert += 2;
      if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got pending=%0d expected 0", exp_q.size()); end
      if (gap_q.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_gap_count: got %0d expected 2", gap_q.size());
      end else begin
         n_assert++;
         if (gap_q[1] != GAP + 1) begin n_fail++; $display("FAIL b2b_gap: got %0d expected %0d", gap_q[1], GAP + 1); end
      end
   endtask

   task automatic test_burst;
      bit ok;
      logic [9:0] v;
      int peak;
      peak = 0;
      gap_q.delete();
      for (int i = 0; i < 12; i++) begin
         v = 10'(10'h040 + i * 37);
         core_out = v;
         if (i <= 8) exp_q.push_back({4'h3, v, 2'b00});
         @(posedge clk);
         @(negedge clk);
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
      end
      n_assert += 2;
      if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL burst_drop: got %0d expected 3", drop_cnt); end
      if (peak != 8)         begin n_fail++; $display("FAIL burst_peak: got %0d expected 8", peak); end
      wait_drain(2000, ok);
      n_assert += 2;
      if (!ok) begin n_fail++; $display("FAIL burst_timeout: got pending=%0d expected 0", exp_q.size()); end
      if (gap_q.size() != 9) begin n_fail++; $display("FAIL burst_frames: got %0d starts expected 9", gap_q.size()); end
      for (int i = 1; i < gap_q.size(); i++) begin
         n_assert++;
         if (gap_q[i] != GAP + 1) begin n_fail++; $display("FAIL burst_gap%0d: got %0d expected %0d", i, gap_q[i], GAP + 1); end
      end
   endtask

   task automatic test_reset_mid_frame;
      bit ok;
      bit found;
      sb_on = 1'b0;
      exp_q.delete();
      core_out = 10'h2A5;
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (cs_n === 1'b0 && mon_bits >= 8) begin found = 1'b1; break; end
      end
      n_assert++;
      if (!found) begin n_fail++; $display("FAIL midrst_reach: got no bit 7 expected frame in progress"); end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_assert += 5;
      if (cs_n !== 1'b1)       begin n_fail++; $display("FAIL midrst_cs_n: got %b expected 1", cs_n); end
      if (sclk !== 1'b0)       begin n_fail++; $display("FAIL midrst_sclk: got %b expected 0", sclk); end
      if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL midrst_level: got %0d expected 0", fifo_level); end
      if (drop_cnt !== 8'd0)   begin n_fail++; $display("FAIL midrst_drop: got %0d expected 0", drop_cnt); end
      if (busy !== 1'b0)       begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      reset = 1'b0;
      @(negedge clk);
      exp_q.push_back({4'h3, 10'h2A5, 2'b00});
      sb_on = 1'b1;
      wait_drain(500, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL midrst_resend: got pending=%0d expected 0", exp_q.size()); end
   endtask

   task automatic test_drop_saturate;
      bit ok;
      logic [7:0] prev;
      sb_on = 1'b0;
      exp_q.delete();
      core_out = 10'h100;
      do_reset();
      prev = 8'd0;
      for (int k = 1; k <= 320; k++) begin
         core_out = ((k % 2) == 1) ? 10'h200 : 10'h100;
         @(posedge clk);
         @(negedge clk);
         n_assert++;
         if (drop_cnt < prev) begin n_fail++; $display("FAIL drop_wrap: got %0d expected >= %0d", drop_cnt, prev); end
         prev = drop_cnt;
         if (k == 20) begin
            n_assert++;
            if (drop_cnt !== 8'd11) begin n_fail++; $display("FAIL drop_early: got %0d expected 11", drop_cnt); end
         end
      end
      n_assert++;
      if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_sat: got %0d expected 255", drop_cnt); end
      wait_drain(3000, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL drop_drain: got busy=%b expected 0", busy); end
   endtask

   task automatic test_clkdiv1;
      int waits, lowc, bits, bad;
      logic [15:0] sh;
      logic ps;
      core_out1 = 10'h001;
      @(negedge clk);
      reset1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset1 = 1'b0;
      waits = 0;
      while (cs_n1 !== 1'b0 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      n_assert++;
      if (waits != 2) begin n_fail++; $display("FAIL div1_start: got %0d cycles expected 2", waits); end
      lowc = 0; bits = 0; bad = 0; sh = '0; ps = 1'b0;
      while (cs_n1 === 1'b0 && lowc < 100) begin
         lowc++;
         if (sclk1 === 1'b1 && ps === 1'b0) begin sh = {sh[14:0], sdata1}; bits++; end
         if (lowc > 1 && sclk1 === ps) bad++;
         ps = sclk1;
         @(negedge clk);
      end
      n_assert += 4;
      if (lowc != 32)        begin n_fail++; $display("FAIL div1_cs_low: got %0d expected 32", lowc); end
      if (bits != 16)        begin n_fail++; $display("FAIL div1_bits: got %0d expected 16", bits); end
      if (sh !== 16'h3004)   begin n_fail++; $display("FAIL div1_frame: got %h expected 3004", sh); end
      if (bad != 0)          begin n_fail++; $display("FAIL div1_sclk_period: got %0d stalls expected 0", bad); end
      repeat (10) @(negedge clk);
      n_assert += 3;
      if (busy1 !== 1'b0)       begin n_fail++; $display("FAIL div1_busy: got %b expected 0", busy1); end
      if (fifo_level1 !== 4'd0) begin n_fail++; $display("FAIL div1_level: got %0d expected 0", fifo_level1); end
      if (drop_cnt1 !== 8'd0)   begin n_fail++; $display("FAIL div1_drop: got %0d expected 0", drop_cnt1); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_burst();
      test_reset_mid_frame();
      test_drop_saturate();
      test_clkdiv1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got time %0t expected completion", $time);
      $fatal(1);
   end

endmodule
